// File: rtl/ft245_tx_batcher.sv
`default_nettype none
// ============================================================================
// Module   : ft245_tx_batcher
// Purpose  : Byte FIFO with a batching controller in front of the FT245
//            bridge. Bytes are held back until a fill threshold, a timeout
//            or a flush, then released as one burst of USB writes.
// Options  : define FT245_TX_BATCHER_STATS_EN to build the tx_count counter.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_tx_batcher #(
   parameter int DEPTH_LOG2 = 6,
   parameter int THRESH     = 16,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  flush,
   input  logic                  _txe,
   input  logic                  _wr,
   output logic                  data_av,
   output logic [7:0]            data_in,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_ovf,
   output logic [15:0]           tx_count
);

   localparam int c_DEPTH = 1 << DEPTH_LOG2;
   // The timer needs to count up to TIMEOUT; keep at least one bit so a
   // TIMEOUT of 0 still elaborates cleanly.
   localparam int c_TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_TMR_W-1:0]    c_TMR_LAST = (TIMEOUT < 1) ? '0 : c_TMR_W'(TIMEOUT - 1);
   localparam logic [c_TMR_W-1:0]    c_TMR_MAX  = c_TMR_W'(TIMEOUT);
   localparam logic [DEPTH_LOG2:0]   c_THRESH   = (DEPTH_LOG2 + 1)'(THRESH);
   localparam logic [DEPTH_LOG2:0]   c_FULL     = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0]   c_ONE      = (DEPTH_LOG2 + 1)'(1);
   // When either parameter degenerates, a single byte is already worth sending.
   localparam logic                  c_FAST     = (TIMEOUT == 0) || (THRESH == 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ACCUM = 2'd1;
   localparam logic [1:0] c_SEND  = 2'd2;

   logic [7:0]            r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;
   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [c_TMR_W-1:0]    r_timer;
   logic                  w_push;
   logic                  w_pop;
   logic [DEPTH_LOG2:0]   w_level_nxt;

   // A push is accepted only if the FIFO was not full before the edge, even
   // when a pop frees a slot on that same edge.
   assign w_push = wr_en && !r_full;
   assign w_pop  = !_wr && !_txe && data_av && !r_empty;

   assign data_av  = (r_state == c_SEND);
   assign data_in  = r_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;
   assign level    = r_level;
   assign overflow = r_overflow;

   // Occupancy after the coming edge, shared by the flags and the FSM.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + c_ONE;
         2'b01:   w_level_nxt = r_level - c_ONE;
         default: w_level_nxt = r_level;
      endcase
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == c_FULL);
         r_empty <= (w_level_nxt == '0);
      end
   end

   // Sticky drop indicator; a drop in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_overflow <= 1'b0;
      end else if (wr_en && r_full) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // Batching decision: accumulate until threshold, timeout or flush, then
   // hold data_av until the FIFO drains.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_push) begin
               w_state_nxt = c_FAST ? c_SEND : c_ACCUM;
            end
         end
         c_ACCUM: begin
            if ((w_level_nxt >= c_THRESH) || (r_timer == c_TMR_LAST) || flush) begin
               w_state_nxt = c_SEND;
            end
         end
         c_SEND: begin
            if (w_level_nxt == '0) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // State register; async reset drops data_av immediately.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Accumulation timer: held at zero outside ACCUM, saturating inside it.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_timer <= '0;
      end else if (r_state != c_ACCUM) begin
         r_timer <= '0;
      end else if (r_timer != c_TMR_MAX) begin
         r_timer <= r_timer + c_TMR_W'(1);
      end
   end

`ifdef FT245_TX_BATCHER_STATS_EN
   logic [15:0] r_tx_count;

   // Running count of bytes handed to the bridge; wraps naturally.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_tx_count <= 16'h0000;
      end else if (w_pop) begin
         r_tx_count <= r_tx_count + 16'd1;
      end
   end

   assign tx_count = r_tx_count;
`else
   assign tx_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ft245_tx_batcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_tx_batcher
// Purpose  : Self-checking bench for ft245_tx_batcher: vector table, directed
//            burst/timeout/overflow/reset sequences and a randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_tx_batcher;

   localparam int DEPTH_LOG2 = 6;
   localparam int DEPTH      = 64;
   localparam int THRESH     = 16;
   localparam int TIMEOUT    = 1000;

   logic        clk;
   logic        _reset;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        flush;
   logic        _txe;
   logic        _wr;
   logic        data_av;
   logic [7:0]  data_in;
   logic        full;
   logic        empty;
   logic [6:0]  level;
   logic        overflow;
   logic        clr_ovf;
   logic [15:0] tx_count;

   int checks = 0;
   int errors = 0;

   ft245_tx_batcher #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .THRESH     (THRESH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk      (clk),
      ._reset   (_reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      ._txe     (_txe),
      ._wr      (_wr),
      .data_av  (data_av),
      .data_in  (data_in),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf),
      .tx_count (tx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr_en;
      logic [7:0] d;
      logic       fl;
      logic       txe;
      logic       wr;
      logic       e_av;
      logic [6:0] e_lvl;
      logic [7:0] e_din;
   } vec_t;

   // Reference model state: plain queue plus send/wait bookkeeping.
   logic [7:0] m_q[$];
   bit         m_send;
   bit         m_wait;
   int         m_age;
   bit         m_ovf;
   int         m_tx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en   = 1'b0;
      wr_data = 8'h00;
      flush   = 1'b0;
      _txe    = 1'b0;
      _wr     = 1'b1;
      clr_ovf = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      _reset = 1'b0;
      repeat (2) tick();
      _reset = 1'b1;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_send = 0;
      m_wait = 0;
      m_age  = 0;
      m_ovf  = 0;
      m_tx   = 0;
   endtask

   // One clock edge of the intended behaviour, from the current inputs.
   task automatic model_step();
      bit was_full;
      bit do_pop;
      was_full = (m_q.size() == DEPTH);
      do_pop   = !_wr && !_txe && m_send && (m_q.size() > 0);
      if (do_pop) begin
         void'(m_q.pop_front());
         m_tx = (m_tx + 1) & 16'hFFFF;
      end
      if (wr_en && !was_full) m_q.push_back(wr_data);
      if (wr_en && was_full) m_ovf = 1;
      else if (clr_ovf)      m_ovf = 0;
      if (m_send) begin
         m_send = (m_q.size() > 0);
      end else if (m_wait) begin
         m_age++;
         if (m_q.size() >= THRESH || m_age >= TIMEOUT || flush) begin
            m_send = 1;
            m_wait = 0;
         end
      end else if (m_q.size() > 0) begin
         if (THRESH <= 1 || TIMEOUT == 0) m_send = 1;
         else begin
            m_wait = 1;
            m_age  = 0;
         end
      end
   endtask

   task automatic model_compare();
      int unsigned exp_tx;
`ifdef FT245_TX_BATCHER_STATS_EN
      exp_tx = m_tx;
`else
      exp_tx = 0;
`endif
      chk("rnd_data_av",  data_av,  m_send);
      chk("rnd_level",    level,    32'(m_q.size()));
      chk("rnd_full",     full,     m_q.size() == DEPTH);
      chk("rnd_empty",    empty,    m_q.size() == 0);
      chk("rnd_data_in",  data_in,  (m_q.size() > 0) ? m_q[0] : 8'h00);
      chk("rnd_overflow", overflow, m_ovf);
      chk("rnd_tx_count", tx_count, exp_tx);
   endtask

   initial begin
      vec_t       tv[11];
      logic [7:0] rx[$];
      int         cnt;
      int         bad;

      idle_inputs();
      _reset = 1'b1;
      #2;
      _reset = 1'b0;
      repeat (3) tick();

      // ---- reset values ----
      chk("rst_data_av",  data_av,  0);
      chk("rst_empty",    empty,    1);
      chk("rst_full",     full,     0);
      chk("rst_level",    level,    0);
      chk("rst_data_in",  data_in,  8'h00);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_count", tx_count, 0);
      _reset = 1'b1;

      // ---- vector table: flush burst, push+pop mid-burst, _txe stall ----
      tv[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 7'd1, 8'h11};
      tv[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 8'h11};
      tv[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 7'd3, 8'h11};
      tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'd3, 8'h11};
      tv[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 8'h22};
      tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 8'h33};
      tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 8'h33};
      tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 8'h55};
      tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00};
      tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 8'h00};
      tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 8'h00};
      for (int i = 0; i < 11; i++) begin
         wr_en   = tv[i].wr_en;
         wr_data = tv[i].d;
         flush   = tv[i].fl;
         _txe    = tv[i].txe;
         _wr     = tv[i].wr;
         tick();
         chk($sformatf("tv%0d_data_av", i), data_av, tv[i].e_av);
         chk($sformatf("tv%0d_level", i),   level,   tv[i].e_lvl);
         chk($sformatf("tv%0d_data_in", i), data_in, tv[i].e_din);
         chk($sformatf("tv%0d_empty", i),   empty,   tv[i].e_lvl == 0);
      end
      idle_inputs();

      // ---- reset asserted mid-burst ----
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
         tick();
      end
      wr_en = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("mid_data_av_before", data_av, 1);
      _wr = 1'b0;
      tick();
      _reset = 1'b0;
      #1;
      chk("mid_rst_data_av", data_av, 0);
      chk("mid_rst_level",   level,   0);
      chk("mid_rst_empty",   empty,   1);
      do_reset();

      // ---- 16-byte threshold burst ----
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
         if (i == 15) chk("thr_av_after15", data_av, 0);
         if (i == 16) chk("thr_av_after16", data_av, 1);
      end
      wr_en = 1'b0;
      _wr = 1'b0;
      rx.delete();
      bad = 0;
      for (int c = 0; c < 16; c++) begin
         if (!data_av) bad++;
         rx.push_back(data_in);
         tick();
      end
      _wr = 1'b1;
      chk("thr_av_gaps",    bad,     0);
      chk("thr_av_fell",    data_av, 0);
      chk("thr_level_end",  level,   0);
      bad = 0;
      for (int i = 0; i < 16; i++) if (rx[i] != 8'(i + 1)) bad++;
      chk("thr_order_errs", bad, 0);

      // ---- single byte waits for the timeout ----
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      cnt = 0;
      while (!data_av && cnt < TIMEOUT + 100) begin
         tick();
         cnt++;
      end
      chk("tmo_latency", cnt, TIMEOUT);
      chk("tmo_data_in", data_in, 8'hA5);
      _wr = 1'b0;
      tick();
      _wr = 1'b1;
      chk("tmo_av_after", data_av, 0);
      chk("tmo_empty",    empty,   1);

      // ---- fill to full, overflow, drain ----
      _txe = 1'b1; _wr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      chk("full_flag",      full,     1);
      chk("full_level",     level,    DEPTH);
      chk("full_ovf_clean", overflow, 0);
      wr_data = 8'hFF;
      tick();
      chk("ovf_set",        overflow, 1);
      chk("ovf_level",      level,    DEPTH);
      // Push while full together with a pop: byte still dropped.
      _txe = 1'b0;
      rx.delete();
      rx.push_back(data_in);
      tick();
      wr_en = 1'b0;
      chk("ovf_pop_level",  level,    DEPTH - 1);
      chk("ovf_pop_sticky", overflow, 1);
      cnt = 0;
      while (data_av && cnt < 100) begin
         rx.push_back(data_in);
         tick();
         cnt++;
      end
      _wr = 1'b1;
      chk("drain_count", rx.size(), DEPTH);
      bad = 0;
      foreach (rx[i]) if (rx[i] != 8'(i)) bad++;
      chk("drain_order_errs", bad, 0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_cleared", overflow, 0);

      // ---- randomized run against the reference model ----
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bit heavy;
         heavy   = ((cyc / 500) % 2) == 1;
         wr_en   = $urandom_range(0, 99) < (heavy ? 85 : 35);
         wr_data = 8'($urandom);
         flush   = $urandom_range(0, 63) == 0;
         _txe    = heavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
         _wr     = $urandom_range(0, 3) == 0;
         clr_ovf = $urandom_range(0, 15) == 0;
         model_step();
         tick();
         model_compare();
      end

      // ---- transfer statistics counter ----
      do_reset();
      _wr = 1'b0;
      wr_en = 1'b1;
      for (int i = 0; i < THRESH; i++) begin
         wr_data = 8'(i);
         tick();
      end
      bad = 0;
`ifdef FT245_TX_BATCHER_STATS_EN
      for (int i = 0; i < 65535; i++) begin
         if (!data_av) bad++;
         tick();
      end
      chk("stats_ffff", tx_count, 16'hFFFF);
      repeat (2) begin
         if (!data_av) bad++;
         tick();
      end
      chk("stats_wrap", tx_count, 16'h0001);
`else
      for (int i = 0; i < 300; i++) begin
         if (!data_av) bad++;
         if (tx_count != 16'h0000) bad++;
         tick();
      end
      chk("stats_tied_zero", tx_count, 16'h0000);
`endif
      chk("stats_stream_gaps", bad, 0);
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
